n_bit_serial_borrow_subtractor: RTL and testbench

Multi-cycle N-bit subtractor computing D = A − B − Bin one W-bit slice per clock. Each slice uses bitwise borrow propagate/generate logic and a borrow ripple; the borrow is registered between slices. It is the subtraction counterpart to the team's N-bit PG carry-ripple adder and is intended for datapaths where area matters more than latency. Operands enter and results leave through valid/ready handshakes.

---
 rtl/sub_pkg.sv | 22 ++
 rtl/w_bit_borrow_slice.sv | 36 +++
 rtl/n_bit_serial_borrow_subtractor.sv | 143 ++++++++++++++
 tb/tb_n_bit_serial_borrow_subtractor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial borrow subtractor.
//   state_t    : controller states (IDLE, RUN, DONE)
//   num_slices : number of W-bit slices in an N-bit operand
//   cnt_width  : width of the slice counter for a given slice count
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int n, input int w);
    return n / w;
  endfunction

  // A single-slice build still needs a 1-bit counter to stay legal.
  function automatic int cnt_width(input int ns);
    return (ns <= 1) ? 1 : $clog2(ns);
  endfunction

endpackage

// File: rtl/w_bit_borrow_slice.sv
// Combinational W-bit borrow-ripple subtractor slice.
//   a, b : W-bit minuend / subtrahend slices
//   bin  : borrow into bit 0 of the slice
//   diff : W-bit difference slice
//   bout : borrow out of the top bit of the slice
module w_bit_borrow_slice
  import sub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   br;

  // g: bit generates a borrow on its own; p: bit passes an incoming borrow.
  always_comb begin
    g     = ~a & b;
    p     = ~(a ^ b);
    br    = '0;
    br[0] = bin;
    diff  = '0;
    for (int i = 0; i < W; i++) begin
      br[i+1] = g[i] | (p[i] & br[i]);
      diff[i] = a[i] ^ b[i] ^ br[i];
    end
    bout = br[W];
  end

endmodule

// File: rtl/n_bit_serial_borrow_subtractor.sv
// Multi-cycle N-bit subtractor: D = A - B - Bin, one W-bit slice per clock,
// with the borrow registered between slices. Valid/ready on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (A, B, Bin)
//   out_valid/out_ready : result handshake (D, Bout, V)
//   D                   : difference modulo 2^N
//   Bout                : 1 when A < B + Bin (unsigned)
//   V                   : signed overflow, only when SUB_OVERFLOW_EN is defined
//
// state | meaning
// IDLE  | ready for operands; accept latches A, B, Bin
// RUN   | one slice per cycle, borrow carried in borrow_q
// DONE  | result held, waiting for out_ready
module n_bit_serial_borrow_subtractor
  import sub_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:1] A,
  input  logic [N:1] B,
  input  logic       Bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:1] D,
`ifdef SUB_OVERFLOW_EN
  output logic       V,
`endif
  output logic       Bout
);

  localparam int NS = num_slices(N, W);
  localparam int CW = cnt_width(NS);
  localparam logic [CW-1:0] K_LAST = CW'(NS - 1);

  generate
    if ((W < 1) || (W > N) || (N % W != 0)) begin : g_bad_params
      $error("n_bit_serial_borrow_subtractor: N must be a multiple of W and 1 <= W <= N");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [N:1]    a_q, b_q, d_q;
  logic          borrow_q, bout_q;
  logic [CW-1:0] k_q;
  logic          accept, last_slice;
  int            base;
  logic [W-1:0]  a_sl, b_sl, diff_sl;
  logic          bout_sl;

  assign accept     = (state_q == IDLE) && in_valid;
  assign last_slice = (k_q == K_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice k occupies bits [k*W+W : k*W+1] of the 1-based operand vectors.
  always_comb begin
    base = int'(k_q) * W + 1;
    a_sl = a_q[base +: W];
    b_sl = b_q[base +: W];
  end

  w_bit_borrow_slice #(.W(W)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (borrow_q),
    .diff (diff_sl),
    .bout (bout_sl)
  );

  // Latching Bin straight into borrow_q lets slice 0 use the same path as
  // every later slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      k_q      <= '0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      borrow_q <= Bin;
      k_q      <= '0;
    end else if (state_q == RUN) begin
      d_q[base +: W] <= diff_sl;
      borrow_q       <= bout_sl;
      if (last_slice) begin
        bout_q <= bout_sl;
        k_q    <= '0;
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic v_q;

  // diff_sl[W-1] is D_N during the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if ((state_q == RUN) && last_slice) begin
      v_q <= (a_q[N] ^ b_q[N]) & (a_q[N] ^ diff_sl[W-1]);
    end
  end

  assign V = v_q;
`endif

  assign D    = d_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_n_bit_serial_borrow_subtractor.sv
module tb_n_bit_serial_borrow_subtractor;

  localparam int N = 64;
  localparam int W = 8;
  localparam int NS = N / W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N:1]    A;
  logic [N:1]    B;
  logic          Bin;
  logic          out_valid;
  logic          out_ready;
  logic [N:1]    D;
  logic          Bout;
`ifdef SUB_OVERFLOW_EN
  logic          V;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  n_bit_serial_borrow_subtractor #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
`ifdef SUB_OVERFLOW_EN
    .V         (V),
`endif
    .Bout      (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic bin, input logic [63:0] exp_d, input logic exp_b);
    int cyc;
    A         = a;
    B         = b;
    Bin       = bin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    Bin      = 1'b0;
    cyc      = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(NS));
    chk({tag, " D"}, D, exp_d);
    chk({tag, " Bout"}, 64'(Bout), 64'(exp_b));
    @(posedge clk); #1;
    chk({tag, " out_valid pulse"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset D", D, 64'd0);
    chk("reset Bout", 64'(Bout), 64'd0);
`ifdef SUB_OVERFLOW_EN
    chk("reset V", 64'(V), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("100-25", 64'd100, 64'd25, 1'b0, 64'd75, 1'b0);
    run_op("25-75", 64'd25, 64'd75, 1'b0, 64'hFFFF_FFFF_FFFF_FFCE, 1'b1);
    run_op("0-0-1", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("max-0", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("x-x-1", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEEF, 1'b1, 64'd0, 1'b0);
    run_op("slice ripple", 64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0);

    // Back-pressure: hold out_ready low for 5 cycles in DONE, offering new operands.
    A = 64'd100; B = 64'd25; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold latency", 64'(cyc), 64'(NS));
    A = 64'd9; B = 64'd1; Bin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold D", D, 64'd75);
      chk("hold in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("hold still valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("hold released", 64'(out_valid), 64'd0);
    chk("hold idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("hold no spurious op", 64'(in_ready), 64'd1);
    chk("hold D kept", D, 64'd75);

    // Reset while slice 3 is being computed.
    A = 64'd100; B = 64'd25; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort D partial", D, 64'd75);
    rst_n = 1'b0;
    #1;
    chk("abort D", D, 64'd0);
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort no out_valid", 64'(seen), 64'd0);
    chk("abort in_ready after", 64'(in_ready), 64'd1);
    run_op("7-3", 64'd7, 64'd3, 1'b0, 64'd4, 1'b0);

`ifdef SUB_OVERFLOW_EN
    run_op("min-1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    chk("min-1 V", 64'(V), 64'd1);
    run_op("5-3", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0);
    chk("5-3 V", 64'(V), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
